// File: rtl/snake_game_core.sv
// snake_game_core: game-logic engine for the snake playfield.
// Advances the snake one cell per executed step_tick, applies the latest
// legal direction request, detects wall/self/food collisions and relocates
// food using a free-running 10-bit LFSR.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               IDLE->PLAY; in OVER/WIN reinitialise to IDLE
//   dir_req, dir_valid  direction request (00 up, 01 down, 10 left, 11 right)
//   step_tick           move strobe
//   food_x, food_y      food cell
//   snake_x_1dim/_y_    64 packed 5-bit slots, slot 0 is the head
//   snake_length        number of valid slots
//   game_state          00 IDLE, 01 PLAY, 10 OVER, 11 WIN
module snake_game_core #(
  parameter int         GRID_W    = 32,
  parameter int         GRID_H    = 24,
  parameter int         MAX_LEN   = 63,
  parameter int         INIT_X    = 10,
  parameter int         INIT_Y    = 10,
  parameter int         FOOD_X0   = 20,
  parameter int         FOOD_Y0   = 20,
  parameter logic [9:0] LFSR_SEED = 10'h2A5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   dir_req,
  input  logic         dir_valid,
  input  logic         step_tick,
  output logic [4:0]   food_x,
  output logic [4:0]   food_y,
  output logic [319:0] snake_x_1dim,
  output logic [319:0] snake_y_1dim,
  output logic [5:0]   snake_length,
  output logic [1:0]   game_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_OVER = 2'b10,
    ST_WIN  = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  localparam logic [5:0] GW6 = 6'(GRID_W);
  localparam logic [5:0] GH6 = 6'(GRID_H);
  localparam logic [5:0] ML6 = 6'(MAX_LEN);
  localparam logic [4:0] IX  = 5'(INIT_X);
  localparam logic [4:0] IY  = 5'(INIT_Y);
  localparam logic [4:0] FX0 = 5'(FOOD_X0);
  localparam logic [4:0] FY0 = 5'(FOOD_Y0);

  state_t     state_q, state_d;
  dir_t       dir_q, pend_q;
  logic [4:0] sx_q [64];
  logic [4:0] sy_q [64];
  logic [5:0] len_q;
  logic [4:0] fx_q, fy_q;
  logic       busy_q;
  logic [9:0] lfsr_q;

  logic              step_go, restart, advance;
  logic              wall_hit, eat, self_hit;
  logic signed [5:0] nx, ny;
  logic [5:0]        len_inc;
  logic [4:0]        cand_x, cand_y;
  logic              cand_hit, cand_ok;
  logic              dir_accept;

  // ---------------------------------------------------------------------------
  // Step evaluation
  // ---------------------------------------------------------------------------
  always_comb begin
    nx = $signed({1'b0, sx_q[0]});
    ny = $signed({1'b0, sy_q[0]});
    case (pend_q)
      DIR_UP:    ny = ny - 6'sd1;
      DIR_DOWN:  ny = ny + 6'sd1;
      DIR_LEFT:  nx = nx - 6'sd1;
      default:   nx = nx + 6'sd1;
    endcase

    // 31+1 wraps to -32 in 6-bit signed, so the negative test also
    // catches the right/bottom edge of a full 32-wide grid.
    wall_hit = (nx < 6'sd0) || (ny < 6'sd0) ||
               (int'(nx) >= GRID_W) || (int'(ny) >= GRID_H);

    eat = (nx[4:0] == fx_q) && (ny[4:0] == fy_q);

    // Without growth the tail slot vacates this step, so it is excluded.
    self_hit = 1'b0;
    for (int unsigned i = 1; i < 64; i++) begin
      if (((i + (eat ? 32'd0 : 32'd1)) < 32'(len_q)) &&
          (sx_q[6'(i)] == nx[4:0]) && (sy_q[6'(i)] == ny[4:0]))
        self_hit = 1'b1;
    end

    step_go = step_tick && (state_q == ST_PLAY) && !busy_q;
    advance = step_go && !wall_hit && !self_hit;
    len_inc = len_q + 6'd1;
    restart = start && ((state_q == ST_OVER) || (state_q == ST_WIN));

    dir_accept = dir_valid &&
                 ((len_q == 6'd1) || (dir_req != {dir_q[1], ~dir_q[0]}));
  end

  // ---------------------------------------------------------------------------
  // Food candidate from the LFSR
  // ---------------------------------------------------------------------------
  always_comb begin
    cand_x   = lfsr_q[4:0];
    cand_y   = lfsr_q[9:5];
    cand_hit = 1'b0;
    for (int unsigned i = 0; i < 64; i++) begin
      if ((i < 32'(len_q)) && (sx_q[6'(i)] == cand_x) && (sy_q[6'(i)] == cand_y))
        cand_hit = 1'b1;
    end
    cand_ok = ({1'b0, cand_x} < GW6) && ({1'b0, cand_y} < GH6) && !cand_hit;
  end

  // ---------------------------------------------------------------------------
  // Game state FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_PLAY;
      ST_PLAY: begin
        if (step_go) begin
          if (wall_hit || self_hit)         state_d = ST_OVER;
          else if (eat && (len_inc == ML6)) state_d = ST_WIN;
        end
      end
      default: if (start) state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 64; i++) begin
        sx_q[6'(i)] <= IX;
        sy_q[6'(i)] <= IY;
      end
      len_q  <= 6'd1;
      dir_q  <= DIR_RIGHT;
      pend_q <= DIR_RIGHT;
      fx_q   <= FX0;
      fy_q   <= FY0;
      busy_q <= 1'b0;
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
      if (restart) begin
        for (int unsigned i = 0; i < 64; i++) begin
          sx_q[6'(i)] <= IX;
          sy_q[6'(i)] <= IY;
        end
        len_q  <= 6'd1;
        dir_q  <= DIR_RIGHT;
        pend_q <= DIR_RIGHT;
        fx_q   <= FX0;
        fy_q   <= FY0;
        busy_q <= 1'b0;
      end else begin
        if (dir_accept) pend_q <= dir_t'(dir_req);
        if (step_go)    dir_q  <= pend_q;
        if (advance) begin
          for (int unsigned i = 63; i >= 1; i--) begin
            sx_q[6'(i)] <= sx_q[6'(i - 1)];
            sy_q[6'(i)] <= sy_q[6'(i - 1)];
          end
          sx_q[0] <= nx[4:0];
          sy_q[0] <= ny[4:0];
          if (eat) begin
            len_q <= len_inc;
            if (len_inc != ML6) busy_q <= 1'b1;
          end
        end
        // Steps are blocked while busy, so set and clear never coincide.
        if (busy_q && cand_ok) begin
          fx_q   <= cand_x;
          fy_q   <= cand_y;
          busy_q <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    snake_x_1dim = '0;
    snake_y_1dim = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      snake_x_1dim[5*i +: 5] = sx_q[6'(i)];
      snake_y_1dim[5*i +: 5] = sy_q[6'(i)];
    end
  end

  assign food_x       = fx_q;
  assign food_y       = fy_q;
  assign snake_length = len_q;
  assign game_state   = state_q;

endmodule

// File: tb/tb_snake_game_core.sv
// Self-checking bench for snake_game_core: directed scenarios plus random
// play, checked against a queue-based model of the game rules.
module tb_snake_game_core;

  localparam int MAXL = 8;
  localparam int GW = 32;
  localparam int GH = 24;
  localparam int UP = 0, DOWN = 1, LEFT = 2, RIGHT = 3;
  localparam int S_IDLE = 0, S_PLAY = 1, S_OVER = 2, S_WIN = 3;

  logic         clk = 1'b0;
  logic         rst_n, start, dir_valid, step_tick;
  logic [1:0]   dir_req;
  logic [4:0]   food_x, food_y;
  logic [319:0] snake_x_1dim, snake_y_1dim;
  logic [5:0]   snake_length;
  logic [1:0]   game_state;

  snake_game_core #(.MAX_LEN(MAXL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dir_req(dir_req),
    .dir_valid(dir_valid), .step_tick(step_tick), .food_x(food_x),
    .food_y(food_y), .snake_x_1dim(snake_x_1dim), .snake_y_1dim(snake_y_1dim),
    .snake_length(snake_length), .game_state(game_state)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  typedef struct { int x; int y; } cell_t;
  cell_t      body[$];
  int         m_dir, m_pend, m_state, m_fx, m_fy;
  bit         m_busy;
  logic [9:0] m_lfsr;
  int         n_total = 0;
  int         n_pass  = 0;

  function automatic int opposite(input int d);
    case (d)
      UP:      return DOWN;
      DOWN:    return UP;
      LEFT:    return RIGHT;
      default: return LEFT;
    endcase
  endfunction

  function automatic bit on_snake(input int x, input int y, input int upto);
    for (int i = 0; i < upto; i++)
      if (body[i].x == x && body[i].y == y) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_init();
    body.delete();
    body.push_back('{x:10, y:10});
    m_dir = RIGHT; m_pend = RIGHT; m_state = S_IDLE;
    m_fx = 20; m_fy = 20; m_busy = 1'b0;
  endtask

  task automatic model_step(input int d);
    int nx, ny, upto;
    bit eat;
    cell_t c;
    nx = body[0].x; ny = body[0].y;
    case (d)
      UP:      ny--;
      DOWN:    ny++;
      LEFT:    nx--;
      default: nx++;
    endcase
    if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
      m_state = S_OVER;
      return;
    end
    eat  = (nx == m_fx && ny == m_fy);
    upto = eat ? body.size() : body.size() - 1;
    if (on_snake(nx, ny, upto)) begin
      m_state = S_OVER;
      return;
    end
    c.x = nx; c.y = ny;
    body.push_front(c);
    if (!eat) void'(body.pop_back());
    else if (body.size() == MAXL) m_state = S_WIN;
    else m_busy = 1'b1;
  endtask

  task automatic model_edge(input bit st, input bit dv, input logic [1:0] dr, input bit tk);
    logic [9:0] cur;
    bit old_busy;
    int old_state, old_dir, old_pend, old_len, cx, cy;
    cur = m_lfsr; old_busy = m_busy; old_state = m_state;
    old_dir = m_dir; old_pend = m_pend; old_len = body.size();
    m_lfsr = {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
    if (old_busy) begin
      cx = int'(cur[4:0]); cy = int'(cur[9:5]);
      if (cx < GW && cy < GH && !on_snake(cx, cy, body.size())) begin
        m_fx = cx; m_fy = cy; m_busy = 1'b0;
      end
    end
    if (tk && old_state == S_PLAY && !old_busy) begin
      model_step(old_pend);
      m_dir = old_pend;
    end
    if (dv && (old_len == 1 || int'(dr) != opposite(old_dir))) m_pend = int'(dr);
    if (st) begin
      if (old_state == S_IDLE) m_state = S_PLAY;
      else if (old_state != S_PLAY) model_init();
    end
  endtask

  // ---------------- stimulus / checking helpers ----------------
  task automatic cycle(input bit st, input bit dv, input logic [1:0] dr, input bit tk);
    start = st; dir_valid = dv; dir_req = dr; step_tick = tk;
    @(posedge clk);
    model_edge(st, dv, dr, tk);
    @(negedge clk);
    start = 1'b0; dir_valid = 1'b0; step_tick = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    logic [319:0] ex, ey, mask;
    ex = '0; ey = '0; mask = '0;
    for (int i = 0; i < body.size(); i++) begin
      ex[5*i +: 5]   = 5'(body[i].x);
      ey[5*i +: 5]   = 5'(body[i].y);
      mask[5*i +: 5] = 5'h1F;
    end
    chk({tag, "/state"}, 320'(game_state), 320'(m_state));
    chk({tag, "/len"}, 320'(snake_length), 320'(body.size()));
    chk({tag, "/food_x"}, 320'(food_x), 320'(m_fx));
    chk({tag, "/food_y"}, 320'(food_y), 320'(m_fy));
    chk({tag, "/slots_x"}, snake_x_1dim & mask, ex);
    chk({tag, "/slots_y"}, snake_y_1dim & mask, ey);
  endtask

  task automatic check_head(input string tag, input int x, input int y);
    chk({tag, "/head_x"}, 320'(snake_x_1dim[4:0]), 320'(x));
    chk({tag, "/head_y"}, 320'(snake_y_1dim[4:0]), 320'(y));
  endtask

  task automatic check_fresh(input string tag);
    logic [319:0] rx, ry;
    rx = {64{5'd10}};
    ry = {64{5'd10}};
    chk({tag, "/all_x"}, snake_x_1dim, rx);
    chk({tag, "/all_y"}, snake_y_1dim, ry);
    chk({tag, "/st"}, 320'(game_state), 320'(0));
    chk({tag, "/ln"}, 320'(snake_length), 320'(1));
    chk({tag, "/fx"}, 320'(food_x), 320'(20));
    chk({tag, "/fy"}, 320'(food_y), 320'(20));
  endtask

  task automatic wait_reloc();
    int n;
    n = 0;
    while (m_busy && n < 1100) begin
      cycle(1'b0, 1'b0, 2'b00, 1'b0);
      n++;
    end
  endtask

  task automatic move(input int d, input bit wait_r);
    cycle(1'b0, 1'b1, 2'(d), 1'b0);
    cycle(1'b0, 1'b0, 2'b00, 1'b1);
    if (wait_r) wait_reloc();
  endtask

  task automatic to_play();
    if (m_state == S_OVER || m_state == S_WIN) cycle(1'b1, 1'b0, 2'b00, 1'b0);
    if (m_state == S_IDLE) cycle(1'b1, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic chase(input int target, input bit wait_r);
    int steps, want, hx, hy;
    steps = 0;
    while (m_state == S_PLAY && body.size() < target && steps < 400) begin
      hx = body[0].x; hy = body[0].y;
      if (hx != m_fx) want = (m_fx > hx) ? RIGHT : LEFT;
      else            want = (m_fy > hy) ? DOWN : UP;
      if (body.size() > 1 && want == opposite(m_dir)) begin
        if (m_dir == LEFT || m_dir == RIGHT) want = (hy > 0) ? UP : DOWN;
        else                                 want = (hx > 0) ? LEFT : RIGHT;
      end
      move(want, wait_r);
      steps++;
      if (!wait_r && m_busy) break;
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int h, v, guard;
    bit ok;
    rst_n = 1'b0; start = 1'b0; dir_valid = 1'b0; dir_req = 2'b00; step_tick = 1'b0;
    model_init();
    m_lfsr = 10'h2A5;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // reset and idle
    check_fresh("reset");
    check_all("reset");
    cycle(1'b0, 1'b0, 2'b00, 1'b1);
    check_all("idle_tick");

    // start together with a tick: PLAY only, no step
    cycle(1'b1, 1'b0, 2'b00, 1'b1);
    check_all("start_tick");
    check_head("start_tick", 10, 10);

    // movement
    repeat (3) move(RIGHT, 1'b1);
    check_head("mv3", 13, 10);
    chk("mv3/slot1_x", 320'(snake_x_1dim[9:5]), 320'(12));
    chk("mv3/len", 320'(snake_length), 320'(1));
    move(LEFT, 1'b1);
    check_head("len1_reverse", 12, 10);
    move(RIGHT, 1'b1);
    check_head("back_right", 13, 10);
    move(UP, 1'b1);
    check_head("mv_up", 13, 9);
    check_all("mv_up");

    // walk to (19,20) and eat the food at (20,20)
    repeat (11) move(DOWN, 1'b1);
    repeat (6) move(RIGHT, 1'b1);
    check_head("pre_eat", 19, 20);
    move(RIGHT, 1'b0);
    check_head("eat", 20, 20);
    chk("eat/len", 320'(snake_length), 320'(2));
    cycle(1'b0, 1'b0, 2'b00, 1'b1);
    check_head("tick_in_reloc", 20, 20);
    wait_reloc();
    ok = (int'(food_x) < GW) && (int'(food_y) < GH) &&
         !on_snake(int'(food_x), int'(food_y), body.size());
    chk("reloc_free_cell", 320'(ok), 320'(1));
    check_all("reloc");

    // reverse request with length 2 is dropped
    move(LEFT, 1'b1);
    check_head("rev_drop", 21, 20);
    check_all("rev_drop");

    // right wall
    guard = 0;
    while (body[0].x < 31 && m_state == S_PLAY && guard < 40) begin
      move(RIGHT, 1'b1);
      guard++;
    end
    move(RIGHT, 1'b1);
    chk("wall_r/state", 320'(game_state), 320'(2));
    check_all("wall_r");
    cycle(1'b0, 1'b0, 2'b00, 1'b1);
    check_all("over_tick");

    // restart from OVER
    cycle(1'b1, 1'b0, 2'b00, 1'b0);
    check_fresh("restart");

    // top wall
    cycle(1'b1, 1'b0, 2'b00, 1'b0);
    repeat (10) move(UP, 1'b1);
    check_head("top_edge", 10, 0);
    move(UP, 1'b1);
    chk("wall_u/state", 320'(game_state), 320'(2));
    check_head("wall_u", 10, 0);
    check_all("wall_u");

    // grow to 5, then turn back into the body
    for (int a = 0; a < 6; a++) begin
      to_play();
      chase(5, 1'b1);
      if (m_state == S_PLAY && body.size() >= 5) break;
    end
    if (m_state == S_PLAY) begin
      h = (m_dir == LEFT || m_dir == RIGHT) ? m_dir : ((body[0].x < 16) ? RIGHT : LEFT);
      move(h, 1'b1);
      v = (body[0].y >= 1) ? UP : DOWN;
      move(v, 1'b1);
      move(opposite(h), 1'b1);
      move(opposite(v), 1'b1);
    end
    check_all("self_loop");

    // grow to MAX_LEN
    for (int a = 0; a < 8; a++) begin
      to_play();
      chase(MAXL, 1'b1);
      if (m_state == S_WIN) break;
    end
    check_all("win");
    cycle(1'b1, 1'b0, 2'b00, 1'b0);
    check_all("win_restart");

    // random play
    for (int i = 0; i < 300; i++) begin
      cycle((m_state != S_PLAY) && ($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            $urandom_range(0, 2) == 0);
      if (i % 5 == 0) check_all("random");
    end

    // asynchronous reset during relocation
    rst_n = 1'b0;
    #1;
    model_init();
    m_lfsr = 10'h2A5;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 2'b00, 1'b0);
    chase(2, 1'b0);
    chk("busy_before_rst", 320'(m_busy), 320'(1));
    rst_n = 1'b0;
    #1;
    model_init();
    m_lfsr = 10'h2A5;
    check_fresh("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 2'b00, 1'b0);
    check_all("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
